// File: rtl/rv32_fetch_pkg.sv
// Shared definitions for the RV32I instruction-fetch sequencer: state codes,
// instruction size, the default halt word and the fetch-address legality rule.
package rv32_fetch_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_OUT   = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_REQ   = ST_REQ,
        S_WAIT  = ST_WAIT,
        S_OUT   = ST_OUT,
        S_HALT  = ST_HALT,
        S_FAULT = ST_FAULT
    } fetch_state_e;

    localparam int unsigned INST_BYTES        = 4;
    localparam logic [31:0] HALT_INST_DEFAULT = 32'h0000_0000;

    // A fetch address is legal when word aligned and the whole word lies in memory.
    function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] mem_bytes);
        return (pc[1:0] == 2'b00) && (pc <= mem_bytes - 32'(INST_BYTES));
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one word request at a time,
// hands the instruction to decode and stops on the halt word or a bad address.
module imem_fetch_ctrl
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 1024,
    parameter logic [31:0] HALT_INST = HALT_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count,
    output logic [2:0]  state_dbg
);

    // Handshake: inst is transferred on a rising edge where inst_valid and
    // inst_ready are both high; once raised, inst_valid, inst and inst_pc hold
    // until that edge or until a redirect withdraws the instruction.

    localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);

    fetch_state_e state_q;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q;
    logic         mem_req_q;
    logic [31:0]  mem_addr_q;
    logic         inst_valid_q;
    logic [31:0]  inst_q;
    logic [31:0]  inst_pc_q;
    logic         halted_q;
    logic         fault_q;
    logic [31:0]  count_q;
    logic         enter_req;

    // Next PC and whether the FSM moves into REQ on this edge; the request pulse
    // is registered on entry so it lines up with the REQ cycle.
    always_comb begin
        pc_d      = pc_q;
        enter_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redirect_valid) pc_d = redirect_pc;
                enter_req = start;
            end
            S_REQ: begin
                if (redirect_valid) pc_d = redirect_pc;
            end
            S_WAIT: begin
                if (redirect_valid)
                    pc_d = redirect_pc;
                else if (mem_rvalid && !kill_q && (mem_rdata != HALT_INST))
                    pc_d = pc_q + 32'(INST_BYTES);
                enter_req = mem_rvalid && (kill_q || redirect_valid);
            end
            S_OUT: begin
                if (redirect_valid) pc_d = redirect_pc;
                enter_req = inst_ready || redirect_valid;
            end
            default: begin
                pc_d      = pc_q;
                enter_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= BOOT_ADDR;
            kill_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= BOOT_ADDR;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
            count_q      <= 32'h0;
        end else begin
            pc_q <= pc_d;
            if (enter_req) begin
                mem_req_q  <= pc_legal(pc_d, MEM_BYTES_W);
                mem_addr_q <= pc_d;
            end else begin
                mem_req_q  <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_REQ;
                end
                S_REQ: begin
                    if (!pc_legal(pc_q, MEM_BYTES_W)) begin
                        fault_q <= 1'b1;
                        state_q <= S_FAULT;
                    end else begin
                        state_q <= S_WAIT;
                        if (redirect_valid) kill_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        // A redirect arriving with the response also makes it stale.
                        if (kill_q || redirect_valid) begin
                            kill_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else if (mem_rdata == HALT_INST) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            inst_q       <= mem_rdata;
                            inst_pc_q    <= pc_q;
                            inst_valid_q <= 1'b1;
                            state_q      <= S_OUT;
                        end
                    end else if (redirect_valid) begin
                        kill_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (inst_ready) count_q <= count_q + 32'd1;
                    if (inst_ready || redirect_valid) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= S_REQ;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;
    assign state_dbg   = state_q;

endmodule
